// File: rtl/ysyx_22040127_iter_divider_if.sv
// rtl/ysyx_22040127_iter_divider_if.sv - request/response handshake bundle for the iterative divider
interface ysyx_22040127_iter_divider_if #(
    parameter int XLEN = 64
);
    logic            div_valid;
    logic            div_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_signed;
    logic            div_word;
    logic            div_rem;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output div_valid, dividend, divisor, div_signed, div_word, div_rem, out_ready,
        input  div_ready, out_valid, result
    );

    modport slave (
        input  div_valid, dividend, divisor, div_signed, div_word, div_rem, out_ready,
        output div_ready, out_valid, result
    );
endinterface

// File: rtl/ysyx_22040127_iter_divider.sv
// rtl/ysyx_22040127_iter_divider.sv - radix-2 restoring divider, RV64M div/rem incl. word forms
module ysyx_22040127_iter_divider #(
    parameter int XLEN = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    ysyx_22040127_iter_divider_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q, result_q;
    logic            q_neg_q, r_neg_q, word_q, rem_sel_q;
    logic            div_ready_q, out_valid_q;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v[31:0];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v[31:0];
        return r;
    endfunction

    // W-form results are always sign-extended from bit 31, unsigned ones included
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic w);
        return w ? sext32(v) : v;
    endfunction

    logic [XLEN-1:0] dvd_ext, dvs_ext, dvd_mag, dvs_mag, min_neg;
    logic            dvd_neg, dvs_neg, div_zero, ovf;

    always_comb begin
        dvd_ext  = bus.div_word ? (bus.div_signed ? sext32(bus.dividend) : zext32(bus.dividend)) : bus.dividend;
        dvs_ext  = bus.div_word ? (bus.div_signed ? sext32(bus.divisor)  : zext32(bus.divisor))  : bus.divisor;
        dvd_neg  = bus.div_signed & dvd_ext[XLEN-1];
        dvs_neg  = bus.div_signed & dvs_ext[XLEN-1];
        dvd_mag  = dvd_neg ? -dvd_ext : dvd_ext;
        dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
        min_neg  = bus.div_word ? sext32({{(XLEN-1){1'b0}}, 1'b1} << 31) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (dvs_ext == '0);
        ovf      = bus.div_signed & (dvd_ext == min_neg) & (dvs_ext == '1);
    end

    logic [XLEN:0]   shifted, trial;
    logic            fits;
    logic [XLEN-1:0] rem_nxt, quo_nxt, q_fix, r_fix, fixed;

    // Dividend bits leave quo_q from the top while quotient bits enter at the bottom
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
        fits    = ~trial[XLEN];
        rem_nxt = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], fits};
        q_fix   = q_neg_q ? -quo_q : quo_q;
        r_fix   = r_neg_q ? -rem_q : rem_q;
        fixed   = fmt(rem_sel_q ? r_fix : q_fix, word_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            word_q      <= 1'b0;
            rem_sel_q   <= 1'b0;
            div_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            div_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.div_valid) begin
                    word_q      <= bus.div_word;
                    rem_sel_q   <= bus.div_rem;
                    q_neg_q     <= dvd_neg ^ dvs_neg;
                    r_neg_q     <= dvd_neg;
                    dvs_q       <= dvs_mag;
                    rem_q       <= '0;
                    // word operands are left-aligned so the MSB tap is always bit XLEN-1
                    quo_q       <= bus.div_word ? (dvd_mag << (XLEN - 32)) : dvd_mag;
                    cnt_q       <= bus.div_word ? CW'(32) : CW'(XLEN);
                    div_ready_q <= 1'b0;
                    if (div_zero || ovf) begin
                        if (div_zero)
                            result_q <= bus.div_rem ? fmt(dvd_ext, bus.div_word) : '1;
                        else
                            result_q <= bus.div_rem ? '0 : fmt(dvd_ext, bus.div_word);
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: if (cnt_q != '0) begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    result_q    <= fixed;
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    div_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.div_ready = div_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_ysyx_22040127_iter_divider.sv
// tb/tb_ysyx_22040127_iter_divider.sv - self-checking bench for the iterative divider
module tb_ysyx_22040127_iter_divider;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    ysyx_22040127_iter_divider_if #(.XLEN(XLEN)) bus ();

    ysyx_22040127_iter_divider #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural rules
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w,
                                    input bit r, output logic [63:0] res, output int lat);
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] q64, r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            lat = 33;
            if (b32 == 0) begin
                q32 = '1; r32 = a32; lat = 1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 0; lat = 1;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            res = r ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end else begin
            lat = 65;
            if (b == 0) begin
                q64 = '1; r64 = a; lat = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = 0; lat = 1;
            end else if (s) begin
                q64 = $signed(a) / $signed(b);
                r64 = $signed(a) % $signed(b);
            end else begin
                q64 = a / b;
                r64 = a % b;
            end
            res = r ? r64 : q64;
        end
    endfunction

    // All tasks start and end 1 time unit after a rising edge
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w, input bit r);
        int n = 0;
        while (!bus.div_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) check("ready_timeout", 64'(n), 64'd0);
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_signed = s;
        bus.div_word   = w;
        bus.div_rem    = r;
        bus.div_valid  = 1'b1;
        @(posedge clk); #1;
        bus.div_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.out_valid && lat < 300);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w, input bit r,
                         output logic [63:0] res, output int lat);
        start_op(a, b, s, w, r);
        wait_valid(lat);
        res = bus.result;
        ack();
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          s;
        bit          w;
        bit          r;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [63:0] res, exp_res, a, b, prev;
        int lat, exp_lat, seen;
        bit s, w, r;

        tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        tbl[1]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        tbl[2]  = '{64'h1234, 64'd0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        tbl[3]  = '{64'h1234, 64'd0, 1, 0, 1, 64'h1234, 1};
        tbl[4]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 64'h8000_0000_0000_0000, 1};
        tbl[5]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 64'h0, 1};
        tbl[6]  = '{64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 64'hFFFF_FFFF_8000_0000, 1};
        tbl[7]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        tbl[8]  = '{64'hABCD_0000_0000_0007, 64'h1234_0000_0000_0000, 0, 1, 1, 64'h7, 1};
        tbl[9]  = '{64'd100, 64'd7, 0, 0, 0, 64'd14, 65};
        tbl[10] = '{64'h1234_5678_FFFF_FFF9, 64'hDEAD_0000_0000_0002, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        tbl[11] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 64'd1, 65};
        tbl[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'd1, 65};

        rst = 1'b1; flush = 1'b0;
        bus.div_valid = 0; bus.out_ready = 0; bus.dividend = 0; bus.divisor = 0;
        bus.div_signed = 0; bus.div_word = 0; bus.div_rem = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(bus.div_ready), 64'd1);
        check("reset_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", bus.result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].w, tbl[i].r, res, lat);
            check($sformatf("tbl%0d_res", i), res, tbl[i].exp);
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
        end

        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom); w = 1'($urandom); r = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 63);
            case ($urandom_range(0, 7))
                0: b = w ? {$urandom, 32'h0} : 64'h0;
                1: begin
                    b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                end
                2: b = {w ? $urandom : 32'h0, 32'($urandom_range(1, 15))};
                3: b = b >> $urandom_range(0, 63);
                default: ;
            endcase
            ref_div(a, b, s, w, r, exp_res, exp_lat);
            do_op(a, b, s, w, r, res, lat);
            check($sformatf("rand%0d_res", i), res, exp_res);
            check($sformatf("rand%0d_lat", i), 64'(lat), 64'(exp_lat));
        end

        // Hold in DONE with back-pressure and stray request pulses
        start_op(64'd100, 64'd7, 0, 0, 0);
        wait_valid(lat);
        check("hold_first", bus.result, 64'd14);
        for (int i = 0; i < 10; i++) begin
            bus.div_valid = 1'(i);
            bus.dividend  = 64'd999;
            bus.divisor   = 64'd3;
            @(posedge clk); #1;
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_res", bus.result, 64'd14);
            check("hold_ready", 64'(bus.div_ready), 64'd0);
        end
        bus.div_valid = 1'b0;
        ack();
        check("hold_idle_ready", 64'(bus.div_ready), 64'd1);
        check("hold_idle_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("hold_no_accept", 64'(bus.div_ready), 64'd1);

        // Flush at CALC cycle 20
        prev = bus.result;
        start_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0);
        repeat (19) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", 64'(bus.div_ready), 64'd1);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_result", bus.result, prev);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        // Flush beats a concurrent accept
        bus.dividend = 64'd50; bus.divisor = 64'd5;
        bus.div_signed = 0; bus.div_word = 0; bus.div_rem = 0;
        bus.div_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        bus.div_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept", 64'(bus.div_ready), 64'd1);

        // Flush beats a concurrent output handshake; result stays
        start_op(64'd50, 64'd5, 0, 0, 0);
        wait_valid(lat);
        bus.out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; flush = 1'b0;
        check("flush_done_valid", 64'(bus.out_valid), 64'd0);
        check("flush_done_res", bus.result, 64'd10);

        do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0, res, lat);
        check("post_flush_res", res, 64'hFFFF_FFFF_FFFF_FFFD);
        check("post_flush_lat", 64'(lat), 64'd65);

        // Asynchronous reset mid-CALC
        start_op(64'd1000, 64'd9, 0, 0, 0);
        repeat (10) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 64'(bus.div_ready), 64'd1);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_idle_valid", 64'(bus.out_valid), 64'd0);
        do_op(64'd1000, 64'd9, 0, 0, 1, res, lat);
        check("post_rst_res", res, 64'd1);
        check("post_rst_lat", 64'(lat), 64'd65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
